// File: rtl/apb_slave_regbank.sv
// APB completer: NUM_REGS x 32-bit register bank (reg 0 = read-only ID) with programmable wait states.
// Optional byte-strobe support is enabled by defining APB_PSTRB_EN.
module apb_slave_regbank #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_1000,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'hA5A5_0001
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic                PWRITE,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_PSTRB_EN
    input  logic [DATA_W/8-1:0] PSTRB,
`endif
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REGS);
    // 33-bit limit so a bank ending at the top of the address space cannot wrap
    localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_W+1)'(4 * NUM_REGS);

    typedef enum logic {IDLE, ACCESS} state_e;

    state_e                             state_q, state_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]    regs_q, regs_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic                               write_q, write_d;
    logic [DATA_W-1:0]                  wdata_q, wdata_d;
    logic                               err_q, err_d;
    logic [3:0]                         cnt_q, cnt_d;
    logic [DATA_W-1:0]                  prdata_q, prdata_d;
    logic                               pready_q, pready_d;
    logic                               pslverr_q, pslverr_d;
    logic [DATA_W/8-1:0]                strb_q, strb_d;

    logic [IDX_W-1:0]                   req_idx;
    logic                               req_err;
    logic                               rd_strb_err;
    logic [DATA_W/8-1:0]                req_strb;

`ifdef APB_PSTRB_EN
    assign req_strb    = PSTRB;
    assign rd_strb_err = !PWRITE && (PSTRB != '0);
`else
    assign req_strb    = '1;
    assign rd_strb_err = 1'b0;
`endif

    assign req_idx = IDX_W'((PADDR - BASE_ADDR) >> 2);
    assign req_err = (PADDR < BASE_ADDR) || ({1'b0, PADDR} >= LIMIT) || (PADDR[1:0] != 2'b00)
                   || (PWRITE && (req_idx == '0)) || rd_strb_err;

    always_comb begin
        state_d   = state_q;
        regs_d    = regs_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        strb_d    = strb_q;
        case (state_q)
            IDLE: begin
                // PSEL with PENABLE already high is not a legal setup phase and is ignored
                if (PSEL && !PENABLE) begin
                    state_d   = ACCESS;
                    idx_d     = req_idx;
                    write_d   = PWRITE;
                    wdata_d   = PWDATA;
                    strb_d    = req_strb;
                    err_d     = req_err;
                    cnt_d     = 4'(WAIT_CYCLES);
                    pready_d  = (WAIT_CYCLES == 0);
                    pslverr_d = req_err && (WAIT_CYCLES == 0);
                    if (!PWRITE)
                        prdata_d = req_err ? '0 : ((req_idx == '0) ? ID_VALUE : regs_q[req_idx]);
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else if (pready_q) begin
                    if (write_q && !err_q) begin
                        for (int b = 0; b < DATA_W/8; b++)
                            if (strb_q[b]) regs_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= IDLE;
            regs_q    <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            strb_q    <= '0;
        end else begin
            state_q   <= state_d;
            regs_q    <= regs_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            strb_q    <= strb_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench: two register banks (1 wait state and 0 wait states) checked against a word-array model.
module tb_apb_slave_regbank;

    localparam int WAITS [2] = '{1, 0};
`ifdef APB_PSTRB_EN
    localparam bit HAS_STRB = 1'b1;
`else
    localparam bit HAS_STRB = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [31:0] paddr   [2];
    logic        pwrite  [2];
    logic        psel    [2];
    logic        penable [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic [31:0] prdata  [2];
    logic        pready  [2];
    logic        pslverr [2];

    logic [31:0] m_regs   [2][16];
    logic [31:0] m_prdata [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 HCLK = ~HCLK;

    apb_slave_regbank #(.WAIT_CYCLES(1)) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(paddr[0]), .PWRITE(pwrite[0]), .PSEL(psel[0]),
        .PENABLE(penable[0]), .PWDATA(pwdata[0]),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb[0]),
`endif
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb_slave_regbank #(.WAIT_CYCLES(0)) u_dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(paddr[1]), .PWRITE(pwrite[1]), .PSEL(psel[1]),
        .PENABLE(penable[1]), .PWDATA(pwdata[1]),
`ifdef APB_PSTRB_EN
        .PSTRB(pstrb[1]),
`endif
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit model_err(input bit wr, input logic [31:0] addr, input logic [3:0] strb);
        int unsigned a = addr;
        if (a < 32'h1000 || a >= 32'h1000 + 4*16 || (a % 4) != 0) return 1'b1;
        if (wr && ((a - 32'h1000) / 4) == 0) return 1'b1;
        if (!wr && HAS_STRB && strb != 4'h0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_prdata[d] = '0;
            for (int i = 0; i < 16; i++) m_regs[d][i] = '0;
        end
    endtask

    // One complete transfer; leaves the bus idle so a following call runs back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb);
        bit exp_err;
        int n;
        int idx;
        logic [3:0] mask;
        exp_err = model_err(wr, addr, strb);
        idx = int'((addr - 32'h1000) / 4);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = addr; pwdata[d] = wd; pstrb[d] = strb;
        @(posedge HCLK); #1;
        penable[d] = 1'b1;
        n = 1;
        while (!pready[d] && n < 40) begin
            @(posedge HCLK); #1;
            n++;
        end
        chk($sformatf("latency[%0d]", d), n, WAITS[d] + 1);
        chk($sformatf("pslverr[%0d] @%08h", d, addr), {31'b0, pslverr[d]}, {31'b0, exp_err});
        if (!wr)
            m_prdata[d] = exp_err ? 32'h0 : (idx == 0 ? 32'hA5A5_0001 : m_regs[d][idx]);
        chk($sformatf("prdata[%0d] @%08h", d, addr), prdata[d], m_prdata[d]);
        if (wr && !exp_err) begin
            mask = HAS_STRB ? strb : 4'hF;
            for (int b = 0; b < 4; b++)
                if (mask[b]) m_regs[d][idx][8*b +: 8] = wd[8*b +: 8];
        end
        @(posedge HCLK); #1;
        chk($sformatf("pready_clr[%0d]", d), {31'b0, pready[d]}, 32'h0);
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int d;
        bit wr;
        logic [3:0] s;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 0; penable[i] = 0; pwrite[i] = 0; paddr[i] = 0; pwdata[i] = 0; pstrb[i] = 0;
        end
        model_reset();
        repeat (3) @(posedge HCLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_prdata", prdata[i], 32'h0);
            chk("rst_pready", {31'b0, pready[i]}, 32'h0);
            chk("rst_pslverr", {31'b0, pslverr[i]}, 32'h0);
        end
        HRESET = 1'b0;
        @(posedge HCLK); #1;

        xfer(0, 0, 32'h1000, 0, 0);
        chk("id_read", prdata[0], 32'hA5A5_0001);
        xfer(0, 1, 32'h1004, 32'hDEAD_BEEF, 4'hF);
        xfer(0, 0, 32'h1004, 0, 0);
        chk("rw_read", prdata[0], 32'hDEAD_BEEF);
        xfer(0, 1, 32'h1000, 32'h1234_5678, 4'hF);
        xfer(0, 1, 32'h1040, 32'h1234_5678, 4'hF);
        xfer(0, 1, 32'h1006, 32'h1234_5678, 4'hF);
        xfer(0, 0, 32'h1000, 0, 0);
        xfer(0, 0, 32'h1004, 0, 0);
`ifdef APB_PSTRB_EN
        xfer(0, 1, 32'h1004, 32'hAABB_CCDD, 4'b0011);
        xfer(0, 0, 32'h1004, 0, 0);
        chk("strb_merge", prdata[0], 32'hDEAD_CCDD);
        xfer(0, 0, 32'h1004, 0, 4'b0001);
`endif

        xfer(1, 1, 32'h1008, 32'h0000_0011, 4'hF);
        xfer(1, 0, 32'h1008, 0, 0);
        chk("b2b_read", prdata[1], 32'h0000_0011);

        // PSEL+PENABLE with no setup phase must not start a transfer
        psel[1] = 1; penable[1] = 1; pwrite[1] = 0; paddr[1] = 32'h1008;
        repeat (2) begin
            @(posedge HCLK); #1;
            chk("idle_ignore", {31'b0, pready[1]}, 32'h0);
        end
        psel[1] = 0; penable[1] = 0;

        // abort: PSEL dropped in a wait-state ACCESS cycle discards the write
        psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 32'h1010; pwdata[0] = 32'hCAFE_F00D;
        pstrb[0] = 4'hF;
        @(posedge HCLK); #1;
        penable[0] = 1;
        chk("abort_wait", {31'b0, pready[0]}, 32'h0);
        psel[0] = 0; penable[0] = 0;
        @(posedge HCLK); #1;
        chk("abort_pready", {31'b0, pready[0]}, 32'h0);
        xfer(0, 0, 32'h1010, 0, 0);

        for (int i = 0; i < 120; i++) begin
            d  = int'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = 32'h0FF8 + $urandom_range(0, 88);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            s = HAS_STRB ? (wr ? 4'($urandom) : ($urandom_range(0, 3) == 0 ? 4'($urandom) : 4'h0)) : 4'hF;
            xfer(d, wr, a, $urandom, s);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge HCLK); #1;
            end
        end

        // reset during the ACCESS phase of a write
        psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 32'h100C; pwdata[0] = 32'hFFFF_FFFF;
        pstrb[0] = 4'hF;
        @(posedge HCLK); #1;
        penable[0] = 1;
        #2 HRESET = 1'b1;
        #1;
        chk("rst_mid_pready", {31'b0, pready[0]}, 32'h0);
        chk("rst_mid_prdata", prdata[0], 32'h0);
        psel[0] = 0; penable[0] = 0;
        model_reset();
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(posedge HCLK); #1;
        xfer(0, 0, 32'h100C, 0, 0);
        chk("rst_discard", prdata[0], 32'h0);
        xfer(1, 0, 32'h1008, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
